// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared state encoding, APB address map and select decode
//               for the AHB-to-APB bridge controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_RENABLE = 3'd2;
    localparam logic [2:0] c_ST_WWAIT   = 3'd3;
    localparam logic [2:0] c_ST_WRITE   = 3'd4;
    localparam logic [2:0] c_ST_WENABLE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_READ    = c_ST_READ,
        ST_RENABLE = c_ST_RENABLE,
        ST_WWAIT   = c_ST_WWAIT,
        ST_WRITE   = c_ST_WRITE,
        ST_WENABLE = c_ST_WENABLE
    } state_t;

    // Three APB slaves in 64 MB windows; the fourth base marks the window end.
    localparam logic [31:0] c_ADDR_SLV0  = 32'h8000_0000;
    localparam logic [31:0] c_ADDR_SLV1  = 32'h8400_0000;
    localparam logic [31:0] c_ADDR_SLV2  = 32'h8800_0000;
    localparam logic [31:0] c_ADDR_LIMIT = 32'h8C00_0000;

    function automatic logic [2:0] addr_to_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= c_ADDR_SLV0 && addr < c_ADDR_SLV1) begin
            sel = 3'b001;
        end else if (addr >= c_ADDR_SLV1 && addr < c_ADDR_SLV2) begin
            sel = 3'b010;
        end else if (addr >= c_ADDR_SLV2 && addr < c_ADDR_LIMIT) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_fsm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_fsm_controller_if
// Description : AHB-side request signals and APB-side outputs of the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_fsm_controller_if;

    logic        valid;
    logic        hwrite;
    logic        hreadyin;
    logic [31:0] haddr;
    logic [31:0] haddr1;
    logic [31:0] hwdata;
    logic [2:0]  tempselx;

    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;

    // master: the bridge controller driving the APB bus
    modport master (
        input  valid, hwrite, hreadyin, haddr, haddr1, hwdata, tempselx,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout
    );

    // slave: the surrounding AHB slave logic / environment
    modport slave (
        output valid, hwrite, hreadyin, haddr, haddr1, hwdata, tempselx,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout
    );

endinterface
`default_nettype wire

// File: rtl/apb_fsm_controller.sv
`default_nettype none
// ============================================================================
// Module      : apb_fsm_controller
// Description : AHB-to-APB bridge FSM; converts accepted AHB transfers into
//               APB setup/access phases with fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_fsm_controller
    import bridge_pkg::*;
(
    input wire                   hclk,
    input wire                   hresetn,
    apb_fsm_controller_if.master bus
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_pselx;
    logic [2:0]  w_pselx_nxt;
    logic [2:0]  r_sel_q;
    logic [2:0]  w_sel_q_nxt;
    logic        r_penable;
    logic        w_penable_nxt;
    logic        r_pwrite;
    logic        w_pwrite_nxt;
    logic        r_hreadyout;
    logic        w_hreadyout_nxt;
    logic [31:0] r_paddr;
    logic [31:0] w_paddr_nxt;
    logic [31:0] r_pwdata;
    logic [31:0] w_pwdata_nxt;

    logic        w_accept;

    assign w_accept = bus.valid & bus.hreadyin;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next output values; every output register is loaded
    // on the edge that enters the state owning that value.
    always_comb begin
        w_state_nxt     = r_state;
        w_pselx_nxt     = r_pselx;
        w_sel_q_nxt     = r_sel_q;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_hreadyout_nxt = r_hreadyout;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;

        case (r_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (w_accept && !bus.hwrite) begin
                    w_state_nxt     = ST_READ;
                    w_paddr_nxt     = bus.haddr;
                    w_pselx_nxt     = bus.tempselx;
                    w_pwrite_nxt    = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_hreadyout_nxt = 1'b0;
                end else if (w_accept) begin
                    // Write data arrives one cycle later, so the select is
                    // parked in r_sel_q and the APB bus stays deselected.
                    w_state_nxt     = ST_WWAIT;
                    w_sel_q_nxt     = bus.tempselx;
                    w_pselx_nxt     = 3'b000;
                    w_penable_nxt   = 1'b0;
                    w_hreadyout_nxt = 1'b0;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_pselx_nxt     = 3'b000;
                    w_penable_nxt   = 1'b0;
                    w_hreadyout_nxt = 1'b1;
                end
            end
            ST_READ: begin
                w_state_nxt     = ST_RENABLE;
                w_penable_nxt   = 1'b1;
                w_hreadyout_nxt = 1'b1;
            end
            ST_WWAIT: begin
                w_state_nxt     = ST_WRITE;
                w_paddr_nxt     = bus.haddr1;
                w_pwdata_nxt    = bus.hwdata;
                w_pselx_nxt     = r_sel_q;
                w_pwrite_nxt    = 1'b1;
                w_penable_nxt   = 1'b0;
                w_hreadyout_nxt = 1'b0;
            end
            ST_WRITE: begin
                w_state_nxt     = ST_WENABLE;
                w_penable_nxt   = 1'b1;
                w_hreadyout_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_pselx_nxt     = 3'b000;
                w_penable_nxt   = 1'b0;
                w_hreadyout_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_pselx     <= 3'b000;
            r_sel_q     <= 3'b000;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_hreadyout <= 1'b1;
            r_paddr     <= 32'h0000_0000;
            r_pwdata    <= 32'h0000_0000;
        end else begin
            r_pselx     <= w_pselx_nxt;
            r_sel_q     <= w_sel_q_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
        end
    end

    assign bus.pselx     = r_pselx;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.hreadyout = r_hreadyout;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: doc/apb_fsm_controller.md
APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

Interface
REQ-001 The port hclk, input, 1 bit, SHALL be the single clock; all state changes occur on its rising edge.
REQ-002 The port hresetn, input, 1 bit, SHALL be the active-low, asynchronous reset.
REQ-003 The port valid, input, 1 bit, SHALL be the AHB-side qualified NONSEQ/SEQ transfer in the bridge window.
REQ-004 The port hwrite, input, 1 bit, SHALL be the current address-phase direction (1 = write, 0 = read).
REQ-005 The port hreadyin, input, 1 bit, SHALL be the AHB bus-ready; an address phase is accepted only when it is 1.
REQ-006 The port haddr, input, 32 bits, SHALL be the current address-phase address.
REQ-007 The port haddr1, input, 32 bits, SHALL be haddr delayed one hclk.
REQ-008 The port hwdata, input, 32 bits, SHALL be the current AHB write data.
REQ-009 The port tempselx, input, 3 bits, SHALL be the one-hot slave select decoded from the current haddr.
REQ-010 The port pselx, output, 3 bits, SHALL be the APB one-hot select.
REQ-011 The port penable, output, 1 bit, SHALL be the APB enable.
REQ-012 The port pwrite, output, 1 bit, SHALL be the APB direction.
REQ-013 The port paddr, output, 32 bits, SHALL be the APB address.
REQ-014 The port pwdata, output, 32 bits, SHALL be the APB write data.
REQ-015 The port hreadyout, output, 1 bit, SHALL be the bridge ready returned to AHB.

Function
REQ-016 The FSM SHALL have the states ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE and ST_WENABLE.
REQ-017 Every output SHALL be registered and Moore-style, loaded on the same edge the state register enters the state that owns the value.
REQ-018 "Accept" SHALL mean valid=1 and hreadyin=1 at a clock edge while in ST_IDLE, ST_RENABLE or ST_WENABLE.
REQ-019 Accept with hwrite=0 SHALL go to ST_READ, loading paddr<=haddr, pselx<=tempselx, pwrite<=0, penable<=0 and hreadyout<=0.
REQ-020 ST_READ SHALL go unconditionally to ST_RENABLE, setting penable<=1 and hreadyout<=1 and holding paddr, pselx and pwrite.
REQ-021 Accept with hwrite=1 SHALL go to ST_WWAIT, capturing tempselx into an internal sel_q and setting pselx<=0, penable<=0 and hreadyout<=0.
REQ-022 ST_WWAIT SHALL go unconditionally to ST_WRITE, loading paddr<=haddr1, pwdata<=hwdata, pselx<=sel_q, pwrite<=1, penable<=0 and hreadyout<=0.
REQ-023 ST_WRITE SHALL go unconditionally to ST_WENABLE, setting penable<=1 and hreadyout<=1 and holding paddr, pwdata, pselx and pwrite.
REQ-024 ST_RENABLE and ST_WENABLE with no accept SHALL go to ST_IDLE, setting pselx<=0, penable<=0 and hreadyout<=1.
REQ-025 ST_RENABLE and ST_WENABLE with an accept SHALL follow REQ-019 or REQ-021, giving back-to-back transfers with no idle cycle.
REQ-026 In ST_IDLE with no accept, the FSM SHALL stay in ST_IDLE with hreadyout=1 and pselx=0.
REQ-027 paddr, pwrite and pwdata SHALL hold their last value outside an active transfer.
REQ-028 valid=1 with hreadyin=0 SHALL be ignored.
REQ-029 tempselx=000 at accept SHALL still run the full sequence, with pselx=000 on APB.
REQ-030 Read latency SHALL be 2 cycles from accept to hreadyout=1, and write latency SHALL be 3 cycles.
REQ-031 The bridge SHALL not drive hrdata; hrdata is prdata passed through the AHB slave interface.

Reset
REQ-032 hresetn=0 SHALL immediately force ST_IDLE, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, sel_q=0 and hreadyout=1, including mid-transfer.
REQ-033 After release, the first accept SHALL be evaluated on the first rising edge at which hresetn=1.

Structure
REQ-034 The state encoding (3-bit localparams) and bridge address-map constants (0x8000_0000, 0x8400_0000, 0x8800_0000, 0x8C00_0000) SHALL live in a shared package, bridge_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; next-state logic and the output register SHALL be in one file.

Verification
REQ-036 Read: valid=1, hwrite=0, haddr=0x8000_0010, tempselx=001 -> next cycle paddr=0x8000_0010, pselx=001, penable=0, hreadyout=0; following cycle penable=1, hreadyout=1; then IDLE.
REQ-037 Write: accept at haddr=0x8400_0020 with hwrite=1, then hwdata=0xDEAD_BEEF -> WWAIT, then WRITE with paddr=0x8400_0020, pwdata=0xDEAD_BEEF, pselx=010, pwrite=1, then WENABLE with penable=1.
REQ-038 Back-to-back: read 0x8800_0000 with a write accepted in RENABLE -> RENABLE goes directly to WWAIT, pselx=100 then 000, and no IDLE cycle occurs.
REQ-039 Gating: valid=1 with hreadyin=0 for 3 cycles -> the FSM stays in IDLE with pselx=0.
REQ-040 Reset: hresetn=0 asserted mid-WRITE -> all outputs take reset values without waiting for a clock edge; after release, valid=0 keeps the FSM in IDLE.
